// File: rtl/truth_table_capture.sv
// Truth-table capture engine: sweeps a 4-input function through all 16 input
// vectors, samples its output after a settle time and compares against a reference.
module truth_table_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] capture_table,
    output logic [4:0]  ones_count,
    output logic        mismatch,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  idx_r;
    logic [3:0]  settle_cnt_r;
    logic [15:0] table_r;
    logic [15:0] exp_r;
    logic [4:0]  ones_r;
    logic        busy_r;
    logic        done_r;
    logic        mismatch_r;
    logic [3:0]  first_fail_r;

    logic        start_run_s;
    logic        sample_s;
    logic        last_s;
    logic [15:0] table_next_s;
    logic [15:0] diff_s;

    // Lowest set bit position of a 16-bit vector; zero when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                pos = 4'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // Next-state decode plus the per-edge control strobes for the datapath.
    always_comb begin
        state_next_s = state_r;
        start_run_s  = 1'b0;
        sample_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = DRIVE;
                    start_run_s  = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            DRIVE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    sample_s = 1'b1;
                    if (idx_r == 4'd15) begin
                        last_s       = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = DRIVE;
                    end
                end else begin
                    state_next_s = DRIVE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Table including the bit sampled this edge, used for the final comparison.
    always_comb begin
        table_next_s        = table_r;
        table_next_s[idx_r] = f;
        diff_s              = table_next_s ^ exp_r;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: vector index, settle timer, captured table and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= 4'd0;
            settle_cnt_r <= 4'd0;
            table_r      <= 16'd0;
            exp_r        <= 16'd0;
            ones_r       <= 5'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mismatch_r   <= 1'b0;
            first_fail_r <= 4'd0;
        end else if (start_run_s) begin
            idx_r        <= 4'd0;
            settle_cnt_r <= 4'd0;
            table_r      <= 16'd0;
            exp_r        <= expected;
            ones_r       <= 5'd0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            mismatch_r   <= 1'b0;
            first_fail_r <= 4'd0;
        end else if (sample_s) begin
            table_r      <= table_next_s;
            ones_r       <= ones_r + {4'd0, f};
            settle_cnt_r <= 4'd0;
            if (last_s) begin
                // Index returns to 0000 rather than starting a 17th vector.
                idx_r        <= 4'd0;
                busy_r       <= 1'b0;
                done_r       <= 1'b1;
                mismatch_r   <= |diff_s;
                first_fail_r <= lowest_set(diff_s);
            end else begin
                idx_r <= idx_r + 4'd1;
            end
        end else if (state_r == DRIVE) begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    assign {a, b, c, d}  = idx_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign capture_table = table_r;
    assign ones_count    = ones_r;
    assign mismatch      = mismatch_r;
    assign first_fail    = first_fail_r;

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the number of clock cycles each input vector is held before f is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a 16-vector capture run.
REQ-005 SHALL have port expected, input, 16, the reference truth table, bit i = expected F for vector i.
REQ-006 SHALL have port f, input, 1, the output of the combinational function under test.
REQ-007 SHALL have ports a, b, c, d, output, 1 each, driving the function inputs A, B, C, D.
REQ-008 SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 SHALL have port done, output, 1, high from run completion until the next run starts or rst.
REQ-010 SHALL have port table, output, 16, the captured truth table, bit i = f sampled for vector i.
REQ-011 SHALL have port ones_count, output, 5, the number of 1 bits captured in table (0..16).
REQ-012 SHALL have port mismatch, output, 1, high when table differs from the latched expected value.
REQ-013 SHALL have port first_fail, output, 4, the lowest index where table and expected differ; valid only when mismatch=1.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE; IDLE->DRIVE or DONE->DRIVE on start=1; DRIVE->DONE after vector 15 is sampled; DONE holds until start or rst.
REQ-015 SHALL map vector index i[3:0] as a=i[3], b=i[2], c=i[1], d=i[0], so vectors run in order 0000..1111.
REQ-016 SHALL, at the edge k where start=1 is accepted, set busy=1, done=0, mismatch=0, first_fail=0, table=0, ones_count=0, a..d=0000 (i=0), and latch expected internally.
REQ-017 SHALL hold each vector i on a..d for exactly SETTLE cycles and sample f into table[i] at edge k+(i+1)*SETTLE, advancing to vector i+1 at the same edge.
REQ-018 SHALL increment ones_count at each sample edge where f=1; saturation is not needed because the maximum is 16.
REQ-019 SHALL, at edge k+16*SETTLE, write table[15], set busy=0, done=1, return a..d to 0000, and update mismatch and first_fail from the final table versus the latched expected value.
REQ-020 SHALL ignore start while busy=1; expected changes during a run SHALL have no effect.
REQ-021 SHALL accept start in DONE as a new run, with behaviour identical to REQ-016.
REQ-022 SHALL keep a..d, table, ones_count, mismatch and first_fail stable in DONE and IDLE.
REQ-023 SHALL use an internal settle counter of 4 bits and a vector index of 4 bits; vector index wrap from 15 SHALL NOT start another vector.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-run, immediately force state IDLE, a=b=c=d=0, busy=0, done=0, table=0, ones_count=0, mismatch=0, first_fail=0, and clear the settle counter and vector index.
REQ-025 SHALL resume normal operation at the first rising edge after rst deasserts, accepting start at that edge.

Verification
REQ-026 SHALL cover: SETTLE=2, f=a&b, expected=16'hF000, start at edge k -> table=16'hF000, ones_count=4, mismatch=0, busy=0 and done=1 at edge k+32.
REQ-027 SHALL cover: SETTLE=2, f=d, expected=16'hAAAB -> table=16'hAAAA, ones_count=8, mismatch=1, first_fail=0.
REQ-028 SHALL cover: SETTLE=1, f=0, expected=0 -> done at edge k+16, table=0, ones_count=0, mismatch=0; a..d checked to step 0..15 once per cycle.
REQ-029 SHALL cover: start pulsed again at vector 5 while busy -> run unaffected and done at the original edge; start in DONE -> table cleared and a new run begins.
REQ-030 SHALL cover: rst asserted asynchronously between edges during vector 7 -> all outputs zero before the next edge; start after release -> a full correct run.
